// File: rtl/act_mon_pkg.sv
// Shared types, default sizes and the saturating-increment helper for the
// NOR4 activity monitor.
package act_mon_pkg;

  localparam int unsigned CNT_W_DEF       = 16;
  localparam int unsigned WIN_W_DEF       = 16;
  localparam int unsigned SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE,
    DONE_ST
  } state_t;

  // Returns {overflow, next}: a value already at maxv holds and flags overflow.
  function automatic logic [32:0] sat_inc(input logic [31:0] v,
                                          input logic [31:0] maxv);
    if (v >= maxv) begin
      return {1'b1, maxv};
    end
    return {1'b0, v + 32'd1};
  endfunction

endpackage

// File: rtl/act_edge_det.sv
// QN synchronizer plus edge detector against a prev register loaded in ARM.
// ACT_GLITCH_FILT_EN: synchronized level must be stable for 2 cycles first.
module act_edge_det
  import act_mon_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rstb,
  input  logic qn,
  input  logic arm,
  input  logic en,
  output logic rise_pulse,
  output logic fall_pulse
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   sq;
  logic                   lvl;
  logic                   prev;

  always_ff @(posedge clk) begin
    if (!rstb) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], qn};
    end
  end

  always_comb sq = sync[SYNC_STAGES-1];

`ifdef ACT_GLITCH_FILT_EN
  logic sq_d;

  // A new level is only accepted once it has been seen on two consecutive cycles.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      sq_d <= 1'b0;
      lvl  <= 1'b0;
    end else begin
      sq_d <= sq;
      if (sq == sq_d) begin
        lvl <= sq;
      end
    end
  end
`else
  always_comb lvl = sq;
`endif

  always_ff @(posedge clk) begin
    if (!rstb) begin
      prev <= 1'b0;
    end else if (arm || en) begin
      prev <= lvl;
    end
  end

  always_comb begin
    rise_pulse = en &  lvl & ~prev;
    fall_pulse = en & ~lvl &  prev;
  end

endmodule

// File: rtl/nor4_activity_monitor.sv
// Counts QN rise/fall transitions over a programmable CLK window per START.
// Optional build macro ACT_GLITCH_FILT_EN enables the edge glitch filter.
module nor4_activity_monitor
  import act_mon_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned WIN_W       = WIN_W_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             CLK,
  input  logic             RSTB,
  input  logic             QN,
  input  logic             START,
  input  logic [WIN_W-1:0] WINDOW,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] RISE_CNT,
  output logic [CNT_W-1:0] FALL_CNT,
  output logic             OVF
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [WIN_W-1:0] REM_LAST = WIN_W'(1);

  state_t           state;
  state_t           state_nx;
  logic [WIN_W-1:0] rem;
  logic             rise_pulse;
  logic             fall_pulse;
  logic [32:0]      rise_inc;
  logic [32:0]      fall_inc;
  logic             unused_inc;

  act_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge (
    .clk        (CLK),
    .rstb       (RSTB),
    .qn         (QN),
    .arm        (state == ARM),
    .en         (state == MEASURE),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse)
  );

  always_ff @(posedge CLK) begin
    if (!RSTB) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    BUSY     = 1'b0;
    DONE     = 1'b0;
    case (state)
      IDLE: begin
        if (START) begin
          state_nx = ARM;
        end
      end
      ARM: begin
        BUSY     = 1'b1;
        state_nx = (rem == '0) ? DONE_ST : MEASURE;
      end
      MEASURE: begin
        BUSY = 1'b1;
        if (rem == REM_LAST) begin
          state_nx = DONE_ST;
        end
      end
      DONE_ST: begin
        DONE     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    rise_inc   = sat_inc(32'(RISE_CNT), 32'(CNT_MAX));
    fall_inc   = sat_inc(32'(FALL_CNT), 32'(CNT_MAX));
    unused_inc = ^{rise_inc, fall_inc};
  end

  always_ff @(posedge CLK) begin
    if (!RSTB) begin
      rem      <= '0;
      RISE_CNT <= '0;
      FALL_CNT <= '0;
      OVF      <= 1'b0;
    end else if (state == IDLE && START) begin
      rem      <= WINDOW;
      RISE_CNT <= '0;
      FALL_CNT <= '0;
      OVF      <= 1'b0;
    end else if (state == MEASURE) begin
      rem <= rem - REM_LAST;
      if (rise_pulse) begin
        RISE_CNT <= rise_inc[CNT_W-1:0];
        if (rise_inc[32]) begin
          OVF <= 1'b1;
        end
      end
      if (fall_pulse) begin
        FALL_CNT <= fall_inc[CNT_W-1:0];
        if (fall_inc[32]) begin
          OVF <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_nor4_activity_monitor.sv
// Bench for nor4_activity_monitor: window-scan reference model checked every
// cycle on a 16-bit and a 4-bit counter instance, plus directed literal checks.
module tb_nor4_activity_monitor;

  localparam int S = 2;
  localparam int N = 4096;

  logic        clk    = 1'b0;
  logic        rstb   = 1'b0;
  logic        qn     = 1'b0;
  logic        start  = 1'b0;
  logic [15:0] window = '0;

  logic        busy, done, ovf;
  logic [15:0] rise, fall;
  logic        busy4, done4, ovf4;
  logic [3:0]  rise4, fall4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nor4_activity_monitor u_dut (
    .CLK(clk), .RSTB(rstb), .QN(qn), .START(start), .WINDOW(window),
    .BUSY(busy), .DONE(done), .RISE_CNT(rise), .FALL_CNT(fall), .OVF(ovf)
  );

  nor4_activity_monitor #(.CNT_W(4)) u_dut4 (
    .CLK(clk), .RSTB(rstb), .QN(qn), .START(start), .WINDOW(window),
    .BUSY(busy4), .DONE(done4), .RISE_CNT(rise4), .FALL_CNT(fall4), .OVF(ovf4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // QN source: constant level or square wave with 'half' cycles per level
  int   qn_mode = 0;
  logic qn_val  = 1'b0;
  int   half    = 4;
  int   phase   = 0;
  always @(negedge clk) begin
    if (qn_mode == 0) qn = qn_val;
    else begin
      qn = (((phase / half) % 2) == 0) ? 1'b1 : 1'b0;
      phase++;
    end
  end

  // Reference model: level history per cycle, counts from a scan of the window
  bit qs[N], rs[N], sv[N], fv[N], lv[N];
  int cyc = 0;
  bit started = 0;
  bit m_run = 0;
  int m_arm = 0, m_done = 0;
  bit m_valid = 1;
  int e_rise = 0, e_fall = 0, e_rise4 = 0, e_fall4 = 0;
  bit e_ovf = 0, e_ovf4 = 0;

  always @(posedge clk) begin
    int k, lo, r, f;
    bit s_v;
    k = cyc;
    if (k < N) begin
      qs[k] = rstb ? qn : 1'b0;
      rs[k] = !rstb;
      lo = k - S + 1;
      s_v = (lo >= 0) ? qs[lo] : 1'b0;
      for (int j = (lo < 0 ? 0 : lo); j <= k; j++) if (rs[j]) s_v = 1'b0;
      sv[k] = s_v;
      if (rs[k] || k < 2) fv[k] = 1'b0;
      else fv[k] = (sv[k-1] == sv[k-2]) ? sv[k-1] : fv[k-1];
`ifdef ACT_GLITCH_FILT_EN
      lv[k] = fv[k];
`else
      lv[k] = sv[k];
`endif
      if (!rstb) begin
        started = 1; m_run = 0; m_valid = 1;
        e_rise = 0; e_fall = 0; e_rise4 = 0; e_fall4 = 0; e_ovf = 0; e_ovf4 = 0;
      end else begin
        if (m_run && k - 1 >= m_done) m_run = 0;
        if (!m_run && start) begin
          m_run = 1; m_arm = k; m_done = k + int'(window) + 1; m_valid = 1;
          e_rise = 0; e_fall = 0; e_rise4 = 0; e_fall4 = 0; e_ovf = 0; e_ovf4 = 0;
        end else if (m_run && k == m_done) begin
          r = 0; f = 0;
          for (int c = m_arm + 1; c < m_done; c++) begin
            if (lv[c] && !lv[c-1]) r++;
            if (!lv[c] && lv[c-1]) f++;
          end
          e_rise = (r > 65535) ? 65535 : r;
          e_fall = (f > 65535) ? 65535 : f;
          e_ovf  = (r > 65535) || (f > 65535);
          e_rise4 = (r > 15) ? 15 : r;
          e_fall4 = (f > 15) ? 15 : f;
          e_ovf4  = (r > 15) || (f > 15);
          m_valid = 1;
        end else if (m_run && k > m_arm) begin
          m_valid = 0;
        end
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    int k;
    bit eb, ed;
    if (started && cyc > 0) begin
      k  = cyc - 1;
      eb = m_run && k >= m_arm && k < m_done;
      ed = m_run && k == m_done;
      chk("busy", 32'(busy), 32'(eb));
      chk("done", 32'(done), 32'(ed));
      chk("busy4", 32'(busy4), 32'(eb));
      chk("done4", 32'(done4), 32'(ed));
      if (m_valid) begin
        chk("rise", 32'(rise), 32'(e_rise));
        chk("fall", 32'(fall), 32'(e_fall));
        chk("ovf", 32'(ovf), 32'(e_ovf));
        chk("rise4", 32'(rise4), 32'(e_rise4));
        chk("fall4", 32'(fall4), 32'(e_fall4));
        chk("ovf4", 32'(ovf4), 32'(e_ovf4));
      end
    end
  end

  // Pulse START with window w; lat = cycles from START cycle to DONE, -1 on timeout
  task automatic run(input int w, input int maxc, output int lat);
    @(negedge clk);
    window = 16'(w);
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    while (done !== 1'b1 && lat < maxc) begin
      @(negedge clk);
      lat++;
    end
    if (done !== 1'b1) lat = -1;
  endtask

  initial begin
    int lat, dcount, first, d;
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_rise", 32'(rise), 0);
    chk("reset_fall", 32'(fall), 0);
    chk("reset_ovf", 32'(ovf), 0);
    rstb = 1'b1;

    // constant QN
    qn_val = 1'b1;
    repeat (5) @(negedge clk);
    run(32, 60, lat);
    chk("t1_latency", 32'(lat), 34);
    chk("t1_rise", 32'(rise), 0);
    chk("t1_fall", 32'(fall), 0);
    chk("t1_ovf", 32'(ovf), 0);

    // square wave 4 high / 4 low
    half = 4; phase = 0; qn_mode = 1;
    repeat (3) @(negedge clk);
    run(64, 100, lat);
    chk("t2_latency", 32'(lat), 66);
    chk("t2_sum", 32'(rise) + 32'(fall), 16);
    d = int'(rise) - int'(fall);
    chk("t2_balance", 32'((d <= 1 && d >= -1) ? 1 : 0), 1);

    // toggle every 2 cycles: 4-bit instance saturates
    half = 2; phase = 0;
    repeat (3) @(negedge clk);
    run(100, 140, lat);
    chk("t3_latency", 32'(lat), 102);
    chk("t3_rise4", 32'(rise4), 15);
    chk("t3_fall4", 32'(fall4), 15);
    chk("t3_ovf4", 32'(ovf4), 1);
    chk("t3_rise16", 32'(rise), 25);
    chk("t3_fall16", 32'(fall), 25);
    chk("t3_ovf16", 32'(ovf), 0);

    // zero window, then START re-pulsed mid-measure
    qn_mode = 0; qn_val = 1'b0;
    repeat (4) @(negedge clk);
    run(0, 10, lat);
    chk("t4_zero_latency", 32'(lat), 2);
    chk("t4_zero_rise", 32'(rise), 0);
    chk("t4_zero_fall", 32'(fall), 0);
    chk("t4_ovf4_cleared", 32'(ovf4), 0);
    @(negedge clk);
    window = 16'd20;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    dcount = 0;
    first  = -1;
    for (int i = 2; i <= 30; i++) begin
      @(negedge clk);
      if (i == 6) begin start = 1'b1; window = 16'd5; end
      else start = 1'b0;
      if (done === 1'b1) begin
        dcount++;
        if (first < 0) first = i;
      end
    end
    start = 1'b0;
    chk("t4_done_at", 32'(first), 22);
    chk("t4_done_once", 32'(dcount), 1);

    // reset mid-measure
    half = 3; phase = 0; qn_mode = 1;
    repeat (3) @(negedge clk);
    window = 16'd40;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rstb = 1'b0;
    @(negedge clk);
    rstb = 1'b1;
    chk("t5_busy", 32'(busy), 0);
    chk("t5_rise", 32'(rise), 0);
    chk("t5_fall", 32'(fall), 0);
    dcount = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done === 1'b1) dcount++;
    end
    chk("t5_no_done", 32'(dcount), 0);

    // single-cycle QN pulse inside the window
    qn_mode = 0; qn_val = 1'b0;
    repeat (5) @(negedge clk);
    window = 16'd20;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    qn_val = 1'b1;
    @(negedge clk);
    qn_val = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("t6_done_seen", 32'(done), 1);
`ifdef ACT_GLITCH_FILT_EN
    chk("t6_rise", 32'(rise), 0);
    chk("t6_fall", 32'(fall), 0);
`else
    chk("t6_rise", 32'(rise), 1);
    chk("t6_fall", 32'(fall), 1);
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
